ula_sequencer_8_bits: RTL and testbench
=======================================

ULA_SEQUENCER_8_BITS -- requirements
Module: ula_sequencer_8_bits

Interface
REQ-001 SHALL have parameter: SETTLE, default 1, ALU settle cycles per iteration (legal 1..4).
REQ-002 SHALL have port: CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: CMD_VALID  input  1  command offered.
REQ-005 SHALL have port: CMD_READY  output  1  command accepted when high with CMD_VALID.
REQ-006 SHALL have port: CMD_OP  input  3  000 add, 001 sub, 010 and, 011 or, 100 not, 101 load, 110 clear, 111 no-op.
REQ-007 SHALL have port: CMD_B  input  8  operand B.
REQ-008 SHALL have port: CMD_CIN  input  1  carry-in (add) / borrow-in (sub).
REQ-009 SHALL have port: CMD_CNT  input  3  iteration count minus one.
REQ-010 SHALL have ports: ALU_A, ALU_B  output  8 each  ALU operands; ALU_X  output  3  ALU select; ALU_CIN  output  1  ALU carry-in.
REQ-011 SHALL have ports: ALU_S  input  8  ALU result; ALU_COUT  input  1  ALU carry/borrow out.
REQ-012 SHALL have ports: RES_VALID  output  1; RES_READY  input  1  result handshake.
REQ-013 SHALL have ports: RES_ACC  output  8  accumulator; RES_C, RES_Z, RES_N  output  1 each  carry, zero, negative flags.
REQ-014 SHALL have port: BUSY  output  1  high when not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-016 CMD_READY SHALL be high only in IDLE with RST low; RES_VALID SHALL be high only in RESP; the two SHALL never be high together.
REQ-017 On accept edge (IDLE, CMD_VALID & CMD_READY), SHALL latch CMD_OP, CMD_B, CMD_CIN, and load the iteration counter with CMD_CNT.
REQ-018 Ops 000-100: accept edge -> ISSUE; settle counter starts at 0.
REQ-019 In ISSUE: ALU_A = ACC, ALU_B = latched B, ALU_X = latched op, ALU_CIN = latched CIN; all registered, stable for the whole ISSUE period.
REQ-020 Each iteration SHALL last exactly SETTLE cycles; on its final edge ACC <= ALU_S, C <= ALU_COUT.
REQ-021 On that edge: iteration counter nonzero -> decrement, restart settle count, stay ISSUE; zero -> RESP.
REQ-022 Every iteration SHALL use the latched CIN (no carry chaining between iterations).
REQ-023 Latency for ops 000-100: RES_VALID high from edge k+(CMD_CNT+1)*SETTLE, k = accept edge.
REQ-024 Op 101: ACC <= CMD_B, C <= 0 on accept edge; op 110: ACC <= 0, C <= 0; op 111: ACC, C unchanged; all three go directly to RESP (RES_VALID from edge k+1), CMD_CNT ignored.
REQ-025 RES_ACC SHALL equal ACC; RES_Z = (ACC == 0); RES_N = ACC[7]; RES_C = C; all continuously driven.
REQ-026 In RESP: RES_VALID held until the edge with RES_READY high, then -> IDLE; RES_ACC/flags unchanged while RES_VALID is high.
REQ-027 CMD_VALID outside IDLE SHALL be ignored; no command buffering.
REQ-028 In IDLE and RESP, ALU_X SHALL hold its last value and ALU_A SHALL track ACC.
REQ-029 ACC arithmetic SHALL be modulo 256; the carry out of bit 7 is reported only via RES_C.

Reset
REQ-030 RST high SHALL immediately force IDLE, ACC=0x00, C=0, counters 0, ALU_A/ALU_B=0x00, ALU_X=000, ALU_CIN=0, RES_VALID=0, BUSY=0.
REQ-031 While RST is high, CMD_READY=0; it rises in IDLE after RST falls.
REQ-032 RST mid-ISSUE or mid-RESP SHALL discard the command and its result.

Verification
REQ-033 SETTLE=1: load B=0x05, then add B=0x03, CIN=0, CNT=0 -> RES_ACC=0x08, C=0, Z=0, N=0, RES_VALID at k+1.
REQ-034 SETTLE=1: ACC=0x05, add B=0x05, CNT=2 -> RES_ACC=0x14, RES_VALID at k+3, BUSY high for 3 cycles.
REQ-035 ACC=0xFF, add B=0x01, CIN=0 -> RES_ACC=0x00, C=1, Z=1, N=0.
REQ-036 ACC=0x03, sub B=0x05, CIN=0 -> RES_ACC=0xFE, C=1, N=1, Z=0.
REQ-037 Backpressure: RES_READY low 5 cycles with CMD_VALID high -> RES_VALID and RES_ACC held, CMD_READY=0, no second command accepted; IDLE one edge after RES_READY rises.
REQ-038 SETTLE=2: add CNT=7, RST pulsed during iteration 3 -> ACC=0x00, RES_VALID never rises, CMD_READY=1 in the first cycle after RST release.

Source files
------------

// File: rtl/ula_sequencer_8_bits.sv
// Command sequencer driving an external 8-bit ALU: repeats one operation
// CMD_CNT+1 times on the accumulator, then presents the result with flags.
module ula_sequencer_8_bits #(
    parameter int SETTLE = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [2:0] CMD_OP,
    input  logic [7:0] CMD_B,
    input  logic       CMD_CIN,
    input  logic [2:0] CMD_CNT,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [2:0] ALU_X,
    output logic       ALU_CIN,
    input  logic [7:0] ALU_S,
    input  logic       ALU_COUT,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic [7:0] RES_ACC,
    output logic       RES_C,
    output logic       RES_Z,
    output logic       RES_N,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic       c_q, c_d;
    logic [2:0] iter_q, iter_d;
    logic [1:0] settle_q, settle_d;
    logic [2:0] op_q, op_d;
    logic [7:0] b_q, b_d;
    logic       cin_q, cin_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            acc_q    <= 8'h00;
            c_q      <= 1'b0;
            iter_q   <= 3'd0;
            settle_q <= 2'd0;
            op_q     <= 3'd0;
            b_q      <= 8'h00;
            cin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            iter_q   <= iter_d;
            settle_q <= settle_d;
            op_q     <= op_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        c_d      = c_q;
        iter_d   = iter_q;
        settle_d = settle_q;
        op_d     = op_q;
        b_d      = b_q;
        cin_d    = cin_q;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    iter_d   = CMD_CNT;
                    settle_d = 2'd0;
                    case (CMD_OP)
                        OP_LOAD: begin
                            acc_d   = CMD_B;
                            c_d     = 1'b0;
                            state_d = RESP;
                        end
                        OP_CLEAR: begin
                            acc_d   = 8'h00;
                            c_d     = 1'b0;
                            state_d = RESP;
                        end
                        OP_NOP: begin
                            state_d = RESP;
                        end
                        default: begin
                            // ALU operands only change for ops the ALU executes,
                            // so ALU_X keeps its last value across load/clear/nop.
                            op_d    = CMD_OP;
                            b_d     = CMD_B;
                            cin_d   = CMD_CIN;
                            state_d = ISSUE;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (settle_q == SETTLE_LAST) begin
                    acc_d    = ALU_S;
                    c_d      = ALU_COUT;
                    settle_d = 2'd0;
                    if (iter_q != 3'd0) begin
                        iter_d = iter_q - 3'd1;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            RESP: begin
                if (RES_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every ALU input comes straight from a register, so it is stable for the
    // whole settle window and ALU_A follows the accumulator in every state.
    assign ALU_A   = acc_q;
    assign ALU_B   = b_q;
    assign ALU_X   = op_q;
    assign ALU_CIN = cin_q;

    assign CMD_READY = (state_q == IDLE) && !RST;
    assign RES_VALID = (state_q == RESP);
    assign BUSY      = (state_q != IDLE);
    assign RES_ACC   = acc_q;
    assign RES_C     = c_q;
    assign RES_Z     = (acc_q == 8'h00);
    assign RES_N     = acc_q[7];

endmodule

// File: tb/tb_ula_sequencer_8_bits.sv
// Bench for ula_sequencer_8_bits: instance 0 uses SETTLE=1, instance 1 SETTLE=2,
// each with its own behavioural ALU and an accumulator reference model.
module tb_ula_sequencer_8_bits;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [2:0] cmd_op    [2];
    logic [7:0] cmd_b     [2];
    logic       cmd_cin   [2];
    logic [2:0] cmd_cnt   [2];
    logic [7:0] alu_a     [2];
    logic [7:0] alu_b     [2];
    logic [2:0] alu_x     [2];
    logic       alu_cin   [2];
    logic [7:0] alu_s     [2];
    logic       alu_cout  [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic [7:0] res_acc   [2];
    logic       res_c     [2];
    logic       res_z     [2];
    logic       res_n     [2];
    logic       busy      [2];

    int total = 0;
    int bad   = 0;
    int m_acc [2];
    int m_c   [2];

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] x, input logic cin);
        logic [8:0] r;
        case (x)
            3'd0:    r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            3'd1:    r = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, ~a};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ula_sequencer_8_bits #(.SETTLE(gi + 1)) dut (
            .CLK       (clk),
            .RST       (rst[gi]),
            .CMD_VALID (cmd_valid[gi]),
            .CMD_READY (cmd_ready[gi]),
            .CMD_OP    (cmd_op[gi]),
            .CMD_B     (cmd_b[gi]),
            .CMD_CIN   (cmd_cin[gi]),
            .CMD_CNT   (cmd_cnt[gi]),
            .ALU_A     (alu_a[gi]),
            .ALU_B     (alu_b[gi]),
            .ALU_X     (alu_x[gi]),
            .ALU_CIN   (alu_cin[gi]),
            .ALU_S     (alu_s[gi]),
            .ALU_COUT  (alu_cout[gi]),
            .RES_VALID (res_valid[gi]),
            .RES_READY (res_ready[gi]),
            .RES_ACC   (res_acc[gi]),
            .RES_C     (res_c[gi]),
            .RES_Z     (res_z[gi]),
            .RES_N     (res_n[gi]),
            .BUSY      (busy[gi])
        );
        assign {alu_cout[gi], alu_s[gi]} = alu_f(alu_a[gi], alu_b[gi], alu_x[gi], alu_cin[gi]);
    end

    // Reference: apply the operation cnt+1 times with plain integer arithmetic.
    task automatic model_cmd(input int i, input int op, input int b, input int cin, input int cnt);
        int t;
        case (op)
            5: begin m_acc[i] = b; m_c[i] = 0; end
            6: begin m_acc[i] = 0; m_c[i] = 0; end
            7: ;
            default: begin
                for (int k = 0; k <= cnt; k++) begin
                    case (op)
                        0: begin t = m_acc[i] + b + cin; m_c[i] = (t > 255) ? 1 : 0; m_acc[i] = t & 255; end
                        1: begin t = m_acc[i] - b - cin; m_c[i] = (t < 0) ? 1 : 0; m_acc[i] = t & 255; end
                        2: begin m_acc[i] = m_acc[i] & b; m_c[i] = 0; end
                        3: begin m_acc[i] = m_acc[i] | b; m_c[i] = 0; end
                        default: begin m_acc[i] = (~m_acc[i]) & 255; m_c[i] = 0; end
                    endcase
                end
            end
        endcase
    endtask

    task automatic do_cmd(input int i, input int op, input int b, input int cin, input int cnt,
                          input int stall, input bit hold_valid);
        int exp_lat, lat, prev_acc, busy_bad;
        logic [10:0] exp_res, got_res;
        prev_acc = m_acc[i];
        exp_lat  = (op < 5) ? (cnt + 1) * (i + 1) : 1;
        @(negedge clk);
        total++;
        if (cmd_ready[i] !== 1'b1)
            $display("FAIL cmd_ready_idle inst=%0d got=%b want=1", i, cmd_ready[i]);
        if (cmd_ready[i] !== 1'b1) bad++;
        cmd_op[i] = op[2:0]; cmd_b[i] = b[7:0]; cmd_cin[i] = cin[0]; cmd_cnt[i] = cnt[2:0];
        cmd_valid[i] = 1'b1;
        @(posedge clk); #1;
        if (hold_valid) begin
            cmd_op[i] = 3'd6; cmd_b[i] = cmd_b[i] ^ 8'hA5;
        end else begin
            cmd_valid[i] = 1'b0;
        end
        model_cmd(i, op, b, cin, cnt);
        if (op < 5) begin
            total++;
            if ({alu_x[i], alu_b[i], alu_cin[i], alu_a[i]} !== {op[2:0], b[7:0], cin[0], prev_acc[7:0]}) begin
                bad++;
                $display("FAIL alu_operands inst=%0d got x=%0d b=%h cin=%b a=%h want x=%0d b=%h cin=%0d a=%h",
                         i, alu_x[i], alu_b[i], alu_cin[i], alu_a[i], op, b, cin, prev_acc);
            end
        end
        lat = 0; busy_bad = 0;
        while (lat < 100) begin
            if (lat > 0 || res_valid[i] !== 1'b1) begin
                @(posedge clk); #1;
            end
            lat++;
            if (res_valid[i] === 1'b1) break;
            if (busy[i] !== 1'b1 || cmd_ready[i] !== 1'b0) busy_bad++;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL latency inst=%0d op=%0d cnt=%0d got=%0d want=%0d", i, op, cnt, lat, exp_lat);
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL busy_during_issue inst=%0d bad_cycles=%0d want=0", i, busy_bad);
        end
        exp_res = {m_acc[i][7:0], m_c[i][0], (m_acc[i] == 0), m_acc[i][7]};
        got_res = {res_acc[i], res_c[i], res_z[i], res_n[i]};
        total++;
        if (got_res !== exp_res || busy[i] !== 1'b1 || cmd_ready[i] !== 1'b0) begin
            bad++;
            $display("FAIL result inst=%0d op=%0d got acc=%h c=%b z=%b n=%b busy=%b rdy=%b want acc=%h c=%0d z=%b n=%b busy=1 rdy=0",
                     i, op, res_acc[i], res_c[i], res_z[i], res_n[i], busy[i], cmd_ready[i],
                     m_acc[i][7:0], m_c[i], exp_res[1], exp_res[0]);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            total++;
            if (res_valid[i] !== 1'b1 || res_acc[i] !== m_acc[i][7:0] || cmd_ready[i] !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold inst=%0d cyc=%0d got valid=%b acc=%h rdy=%b want valid=1 acc=%h rdy=0",
                         i, s, res_valid[i], res_acc[i], cmd_ready[i], m_acc[i][7:0]);
            end
        end
        @(negedge clk);
        res_ready[i] = 1'b1; cmd_valid[i] = 1'b0;
        @(posedge clk); #1;
        res_ready[i] = 1'b0;
        total++;
        if (res_valid[i] !== 1'b0 || cmd_ready[i] !== 1'b1 || busy[i] !== 1'b0 || res_acc[i] !== m_acc[i][7:0]) begin
            bad++;
            $display("FAIL return_idle inst=%0d got valid=%b rdy=%b busy=%b acc=%h want valid=0 rdy=1 busy=0 acc=%h",
                     i, res_valid[i], cmd_ready[i], busy[i], res_acc[i], m_acc[i][7:0]);
        end
        $display("txn inst=%0d op=%0d b=%h cin=%0d cnt=%0d stall=%0d lat=%0d acc=%h c=%b",
                 i, op, b, cin, cnt, stall, lat, res_acc[i], res_c[i]);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cmd_valid[i] = 1'b0; res_ready[i] = 1'b0;
            cmd_op[i] = 3'd0; cmd_b[i] = 8'h00; cmd_cin[i] = 1'b0; cmd_cnt[i] = 3'd0;
            m_acc[i] = 0; m_c[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cmd_ready[i] !== 1'b0 || res_valid[i] !== 1'b0 || busy[i] !== 1'b0 || res_acc[i] !== 8'h00 ||
                res_c[i] !== 1'b0 || res_z[i] !== 1'b1 || alu_a[i] !== 8'h00 || alu_b[i] !== 8'h00 ||
                alu_x[i] !== 3'd0 || alu_cin[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got rdy=%b vld=%b busy=%b acc=%h c=%b z=%b a=%h b=%h x=%0d cin=%b want all zero with z=1",
                         i, cmd_ready[i], res_valid[i], busy[i], res_acc[i], res_c[i], res_z[i],
                         alu_a[i], alu_b[i], alu_x[i], alu_cin[i]);
            end
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cmd_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_reset inst=%0d got=%b want=1", i, cmd_ready[i]);
            end
        end
    endtask

    task automatic test_directed();
        do_cmd(0, 5, 8'h05, 0, 0, 0, 0);
        do_cmd(0, 0, 8'h03, 0, 0, 0, 0);
        total++;
        if ({res_acc[0], res_c[0], res_z[0], res_n[0]} !== {8'h08, 3'b000}) begin
            bad++;
            $display("FAIL add_basic got acc=%h c=%b z=%b n=%b want acc=08 c=0 z=0 n=0", res_acc[0], res_c[0], res_z[0], res_n[0]);
        end
        do_cmd(0, 5, 8'h05, 0, 0, 0, 0);
        do_cmd(0, 0, 8'h05, 0, 2, 0, 0);
        total++;
        if (res_acc[0] !== 8'h14) begin
            bad++;
            $display("FAIL add_repeat got acc=%h want acc=14", res_acc[0]);
        end
        do_cmd(0, 5, 8'hFF, 0, 0, 0, 0);
        do_cmd(0, 0, 8'h01, 0, 0, 0, 0);
        total++;
        if ({res_acc[0], res_c[0], res_z[0], res_n[0]} !== {8'h00, 3'b110}) begin
            bad++;
            $display("FAIL add_wrap got acc=%h c=%b z=%b n=%b want acc=00 c=1 z=1 n=0", res_acc[0], res_c[0], res_z[0], res_n[0]);
        end
        do_cmd(0, 5, 8'h03, 0, 0, 0, 0);
        do_cmd(0, 1, 8'h05, 0, 0, 0, 0);
        total++;
        if ({res_acc[0], res_c[0], res_z[0], res_n[0]} !== {8'hFE, 3'b101}) begin
            bad++;
            $display("FAIL sub_borrow got acc=%h c=%b z=%b n=%b want acc=fe c=1 z=0 n=1", res_acc[0], res_c[0], res_z[0], res_n[0]);
        end
    endtask

    task automatic test_backpressure();
        do_cmd(0, 0, 8'h11, 1, 1, 5, 1);
        do_cmd(1, 5, 8'h80, 0, 3, 5, 1);
        do_cmd(1, 1, 8'h07, 1, 2, 5, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 50; n++) begin
            do_cmd(n % 2, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_issue();
        do_cmd(1, 5, 8'h21, 0, 0, 0, 0);
        @(negedge clk);
        cmd_op[1] = 3'd0; cmd_b[1] = 8'h10; cmd_cin[1] = 1'b0; cmd_cnt[1] = 3'd7;
        cmd_valid[1] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        m_acc[1] = 0; m_c[1] = 0;
        total++;
        if (res_acc[1] !== 8'h00 || busy[1] !== 1'b0 || cmd_ready[1] !== 1'b0 || res_valid[1] !== 1'b0 ||
            alu_x[1] !== 3'd0 || alu_b[1] !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_issue got acc=%h busy=%b rdy=%b vld=%b x=%0d b=%h want all zero",
                     res_acc[1], busy[1], cmd_ready[1], res_valid[1], alu_x[1], alu_b[1]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        total++;
        if (cmd_ready[1] !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_mid_reset got=%b want=1", cmd_ready[1]);
        end
        begin
            int seen = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (res_valid[1] !== 1'b0 || res_acc[1] !== 8'h00) seen++;
            end
            total++;
            if (seen != 0) begin
                bad++;
                $display("FAIL no_result_after_reset got bad_cycles=%0d want=0", seen);
            end
        end
        $display("txn inst=1 reset mid-issue acc=%h", res_acc[1]);
        do_cmd(1, 0, 8'h02, 0, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
